// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: round-robin arbiter that shares a single-port synchronous
// memory between instruction fetch (I), CPU load/store (D) and an external
// loader/debug master (X). One access is in flight at a time; the granted
// requester gets a one-cycle ack when the fixed-latency read data is valid.
module rv32i_mem_arbiter #(
    parameter int MEM_LAT       = 1,
    parameter int RR_RESET_LAST = 2
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port (read-only)
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    // CPU data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    // external master port
    input  logic        x_req,
    input  logic        x_we,
    input  logic [3:0]  x_be,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    output logic [31:0] x_rdata,
    output logic        x_ack,
    // memory macro side
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    // status
    output logic [2:0]  gnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] LAT_C       = 3'(MEM_LAT);
    localparam logic [1:0] LAST_INIT_C = 2'(RR_RESET_LAST);

    state_e      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [2:0]  req_vec_s;
    logic [2:0]  pick_idle_s;
    logic [2:0]  pick_rearb_s;
    logic        ack_cycle_s;
    logic        sel_we_s;
    logic [3:0]  sel_be_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        unused_s;

    // Round-robin pick: search starts one past the last winner and wraps.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        res = 3'b000;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (req[c0]) begin
            res[c0] = 1'b1;
        end else if (req[c1]) begin
            res[c1] = 1'b1;
        end else if (req[c2]) begin
            res[c2] = 1'b1;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // One-hot grant to requester index (0=I, 1=D, 2=X).
    function automatic logic [1:0] onehot_idx(input logic [2:0] g);
        logic [1:0] idx;
        if (g[2]) begin
            idx = 2'd2;
        end else if (g[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    assign req_vec_s    = {x_req, d_req, i_req};
    assign pick_idle_s  = rr_pick(req_vec_s, last_q);
    // the requester just acked sits out this arbitration round
    assign pick_rearb_s = rr_pick(req_vec_s & ~gnt_q, last_q);
    assign ack_cycle_s  = (state_q == ST_WAIT) && (cnt_q == 3'd1);
    // word address only: byte offset bits of the request addresses are ignored
    assign unused_s     = ^{i_addr[1:0], d_addr[1:0], x_addr[1:0], sel_addr_s[1:0]};

    // State, grant, round-robin pointer and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            last_q  <= LAST_INIT_C;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE and on the ACK edge, count latency in WAIT.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_idle_s != 3'b000) begin
                    gnt_d   = pick_idle_s;
                    last_d  = onehot_idx(pick_idle_s);
                    state_d = ST_ISSUE;
                end else begin
                    gnt_d   = 3'b000;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_C;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    cnt_d = 3'd0;
                    if (pick_rearb_s != 3'b000) begin
                        gnt_d   = pick_rearb_s;
                        last_d  = onehot_idx(pick_rearb_s);
                        state_d = ST_ISSUE;
                    end else begin
                        gnt_d   = 3'b000;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Request mux steered by the registered grant; fetch is always a read.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_be_s    = 4'b1111;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        case (gnt_q)
            3'b001: begin
                sel_addr_s  = i_addr;
            end
            3'b010: begin
                sel_we_s    = d_we;
                sel_be_s    = d_be;
                sel_addr_s  = d_addr;
                sel_wdata_s = d_wdata;
            end
            3'b100: begin
                sel_we_s    = x_we;
                sel_be_s    = x_be;
                sel_addr_s  = x_addr;
                sel_wdata_s = x_wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
            end
        endcase
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & sel_we_s;
    assign mem_be    = mem_we ? sel_be_s : 4'b1111;
    assign mem_addr  = sel_addr_s[31:2];
    assign mem_wdata = sel_wdata_s;

    assign i_ack   = ack_cycle_s & gnt_q[0];
    assign d_ack   = ack_cycle_s & gnt_q[1];
    assign x_ack   = ack_cycle_s & gnt_q[2];
    assign i_rdata = i_ack ? mem_rdata : 32'h0000_0000;
    assign d_rdata = d_ack ? mem_rdata : 32'h0000_0000;
    assign x_rdata = x_ack ? mem_rdata : 32'h0000_0000;

    assign gnt  = gnt_q;
    assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: instance u_dut uses MEM_LAT=2,
// instance u_dut1 uses MEM_LAT=1. Both share clk and reset.
module tb_rv32i_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // MEM_LAT=2 instance signals
    logic        i_req = 1'b0, d_req = 1'b0, x_req = 1'b0;
    logic        d_we = 1'b0, x_we = 1'b0;
    logic [3:0]  d_be = 4'h0, x_be = 4'h0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, x_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0, x_wdata = 32'h0, mem_rdata = 32'h0;
    logic [31:0] i_rdata, d_rdata, x_rdata, mem_wdata;
    logic        i_ack, d_ack, x_ack, mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [2:0]  gnt;

    // MEM_LAT=1 instance signals
    logic        b_i_req = 1'b0, b_d_req = 1'b0, b_x_req = 1'b0;
    logic [31:0] b_i_addr = 32'h0, b_d_addr = 32'h0, b_x_addr = 32'h0;
    logic [31:0] b_mem_rdata = 32'h0;
    logic [31:0] b_i_rdata, b_d_rdata, b_x_rdata, b_mem_wdata;
    logic        b_i_ack, b_d_ack, b_x_ack, b_mem_en, b_mem_we, b_busy;
    logic [3:0]  b_mem_be;
    logic [29:0] b_mem_addr;
    logic [2:0]  b_gnt;

    int checks = 0;
    int errors = 0;

    rv32i_mem_arbiter #(.MEM_LAT(2), .RR_RESET_LAST(2)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .x_req(x_req), .x_we(x_we), .x_be(x_be), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_rdata(x_rdata), .x_ack(x_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .gnt(gnt), .busy(busy)
    );

    rv32i_mem_arbiter #(.MEM_LAT(1), .RR_RESET_LAST(2)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
        .d_req(b_d_req), .d_we(1'b0), .d_be(4'b0000), .d_addr(b_d_addr),
        .d_wdata(32'h0000_0000), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .x_req(b_x_req), .x_we(1'b0), .x_be(4'b0000), .x_addr(b_x_addr),
        .x_wdata(32'h0000_0000), .x_rdata(b_x_rdata), .x_ack(b_x_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .gnt(b_gnt), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [2:0]  exp_gnt3  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [29:0] exp_addr3 [4] = '{30'h8, 30'h80, 30'hC0, 30'h8};
    logic        prev_en;

    initial begin
        // reset state
        tick();
        tick();
        check("rst_gnt", gnt, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_acks", {x_ack, d_ack, i_ack}, 3'b000);

        // 1: single fetch, MEM_LAT=2
        reset = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h0000_0010;
        mem_rdata = 32'h0013_0093;
        tick();
        check("t1_mem_en", mem_en, 1'b1);
        check("t1_mem_addr", mem_addr, 30'h4);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_mem_be", mem_be, 4'b1111);
        check("t1_gnt_c1", gnt, 3'b001);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_no_ack_c2", i_ack, 1'b0);
        check("t1_en_c2", mem_en, 1'b0);
        check("t1_gnt_c2", gnt, 3'b001);
        check("t1_rdata_c2", i_rdata, 32'h0);
        tick();
        check("t1_ack_c3", i_ack, 1'b1);
        check("t1_rdata_c3", i_rdata, 32'h0013_0093);
        check("t1_gnt_c3", gnt, 3'b001);
        tick();
        i_req = 1'b0;
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_gnt", gnt, 3'b000);
        check("t1_idle_ack", i_ack, 1'b0);

        // 2: store from D
        d_req = 1'b1;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_addr = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        tick();
        check("t2_mem_en", mem_en, 1'b1);
        check("t2_mem_we", mem_we, 1'b1);
        check("t2_mem_be", mem_be, 4'b0011);
        check("t2_mem_addr", mem_addr, 30'h40);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t2_gnt", gnt, 3'b010);
        tick();
        check("t2_no_ack", d_ack, 1'b0);
        check("t2_en_off", mem_en, 1'b0);
        check("t2_we_off", mem_we, 1'b0);
        check("t2_be_read", mem_be, 4'b1111);
        tick();
        check("t2_d_ack", d_ack, 1'b1);
        check("t2_other_acks", {x_ack, i_ack}, 2'b00);
        check("t2_i_rdata0", i_rdata, 32'h0);
        tick();
        d_req = 1'b0;
        d_we = 1'b0;
        check("t2_idle", busy, 1'b0);

        // 3: all three requesters held high from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0020;
        d_req = 1'b1; d_addr = 32'h0000_0200;
        x_req = 1'b1; x_addr = 32'h0000_0300;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_issue_gnt", gnt, exp_gnt3[k]);
            check("t3_issue_en", mem_en, 1'b1);
            check("t3_issue_addr", mem_addr, exp_addr3[k]);
            check("t3_issue_we", mem_we, 1'b0);
            tick();
            check("t3_wait_acks", {x_ack, d_ack, i_ack}, 3'b000);
            tick();
            check("t3_ack_vec", {x_ack, d_ack, i_ack}, exp_gnt3[k]);
        end
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        tick();
        reset = 1'b0;

        // 4: sole D requester held high: ISSUE, WAIT, ACK, IDLE, ISSUE ...
        d_req = 1'b1;
        d_addr = 32'h0000_0040;
        prev_en = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t4_mem_en", mem_en, ((k % 4) == 0) ? 1'b1 : 1'b0);
            check("t4_d_ack", d_ack, ((k % 4) == 2) ? 1'b1 : 1'b0);
            check("t4_adjacent_en", prev_en & mem_en, 1'b0);
            prev_en = mem_en;
        end
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        reset = 1'b0;

        // 5: reset during WAIT abandons the access
        i_req = 1'b1;
        i_addr = 32'h0000_0010;
        tick();
        check("t5_issue", mem_en, 1'b1);
        tick();
        check("t5_in_wait", busy, 1'b1);
        reset = 1'b1;
        d_req = 1'b1;
        x_req = 1'b1;
        #1;
        check("t5_rst_gnt", gnt, 3'b000);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_en", mem_en, 1'b0);
        check("t5_rst_ack", i_ack, 1'b0);
        tick();
        check("t5_rst_ack2", i_ack, 1'b0);
        reset = 1'b0;
        tick();
        check("t5_first_gnt", gnt, 3'b001);
        check("t5_first_en", mem_en, 1'b1);
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
        tick();
        reset = 1'b0;

        // 6: MEM_LAT=1, last=0 after a fetch, then D and X together
        b_i_req = 1'b1;
        b_i_addr = 32'h0000_0000;
        b_mem_rdata = 32'hCAFE_0001;
        tick();
        check("t6_i_gnt", b_gnt, 3'b001);
        tick();
        check("t6_i_ack", b_i_ack, 1'b1);
        check("t6_i_rdata", b_i_rdata, 32'hCAFE_0001);
        tick();
        b_i_req = 1'b0;
        b_d_req = 1'b1; b_d_addr = 32'h0000_0044;
        b_x_req = 1'b1; b_x_addr = 32'h0000_0088;
        check("t6_idle", b_busy, 1'b0);
        tick();
        check("t6_d_gnt", b_gnt, 3'b010);
        check("t6_d_addr", b_mem_addr, 30'h11);
        tick();
        check("t6_d_ack", b_d_ack, 1'b1);
        check("t6_x_noack", b_x_ack, 1'b0);
        check("t6_d_gnt_hold", b_gnt, 3'b010);
        tick();
        check("t6_x_gnt", b_gnt, 3'b100);
        check("t6_x_en", b_mem_en, 1'b1);
        check("t6_x_addr", b_mem_addr, 30'h22);
        tick();
        check("t6_x_ack", b_x_ack, 1'b1);
        check("t6_d_noack", b_d_ack, 1'b0);
        tick();
        check("t6_d_again", b_gnt, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
